// File: rtl/commit_trace_if.sv
// ---------------------------------------------------------------------------
// commit_trace_if
//   Bundles the expected-record push port and the processor retire-side
//   observation signals that feed commit_trace_checker.
//
//   Push port  : exp_valid, exp_ready, exp_kind[1:0], exp_addr[15:0],
//                exp_data[15:0]  (kind 0=REG 1=LOAD 2=STORE 3=HALT)
//   Retire side: RegWrite, WriteRegister[2:0], WriteData[15:0], MemRead,
//                MemWrite, MemAddress[15:0], MemDataIn[15:0],
//                MemDataOut[15:0], Halt
//
//   master : drives records and observations (trace source / processor)
//   slave  : the checker, which only returns exp_ready
// ---------------------------------------------------------------------------
interface commit_trace_if;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_kind;
    logic [15:0] exp_addr;
    logic [15:0] exp_data;

    logic        RegWrite;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;
    logic        Halt;

    modport master (
        output exp_valid, exp_kind, exp_addr, exp_data,
        output RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
        output MemAddress, MemDataIn, MemDataOut, Halt,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_kind, exp_addr, exp_data,
        input  RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
        input  MemAddress, MemDataIn, MemDataOut, Halt,
        output exp_ready
    );
endinterface

// File: rtl/commit_trace_checker.sv
// ---------------------------------------------------------------------------
// commit_trace_checker
//   Golden-trace checker for FPGA/emulation runs. Expected commit records are
//   pushed into a DEPTH-entry FIFO; every cycle the retire-side events
//   (REG, LOAD, STORE, HALT in that order) are compared against the FIFO head
//   entries. The first divergence latches mismatch plus diagnostics; a clean
//   HALT latches done. Both are terminal until rst.
//
//   Ports
//     clk, rst    : clock, asynchronous active-high reset
//     bus         : commit_trace_if.slave (push port + retire observation)
//     mismatch    : sticky, divergence detected
//     done        : sticky, HALT matched cleanly
//     err_kind    : kind of the observed event that failed
//     err_code    : 0 = kind/addr/data compare fail, 1 = FIFO underflow
//     rec_index   : records consumed before the failing record
//     inst_count  : cycles with Halt|RegWrite|MemWrite while running
// ---------------------------------------------------------------------------
module commit_trace_checker #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    commit_trace_if.slave     bus,
    output logic              mismatch,
    output logic              done,
    output logic [1:0]        err_kind,
    output logic              err_code,
    output logic [CNT_W-1:0]  rec_index,
    output logic [CNT_W-1:0]  inst_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] K_REG   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_HALT  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FAIL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Record compare: kind must agree; REG looks only at the 3-bit register
    // index, HALT carries no payload.
    function automatic logic rec_match(
        input logic [1:0]  ev_k,
        input logic [15:0] ev_a,
        input logic [15:0] ev_d,
        input logic [1:0]  rec_k,
        input logic [15:0] rec_a,
        input logic [15:0] rec_d
    );
        if (ev_k != rec_k) return 1'b0;
        case (ev_k)
            K_REG:   return (rec_a[2:0] == ev_a[2:0]) && (rec_d == ev_d);
            K_HALT:  return 1'b1;
            default: return (rec_a == ev_a) && (rec_d == ev_d);
        endcase
    endfunction

    // Control state
    state_t            state_q,      state_d;
    logic [AW-1:0]     rd_ptr_q,     rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q,     wr_ptr_d;
    logic [CW-1:0]     count_q,      count_d;
    logic              mismatch_q,   mismatch_d;
    logic              done_q,       done_d;
    logic [1:0]        err_kind_q,   err_kind_d;
    logic              err_code_q,   err_code_d;
    logic [CNT_W-1:0]  rec_index_q,  rec_index_d;
    logic [CNT_W-1:0]  inst_count_q, inst_count_d;

    // FIFO storage (data only, never reset)
    logic [1:0]        kind_mem_q [DEPTH];
    logic [15:0]       addr_mem_q [DEPTH];
    logic [15:0]       data_mem_q [DEPTH];

    logic              in_run;
    logic              exp_ready_w;
    logic              push;

    logic [1:0]        ev_kind [4];
    logic [15:0]       ev_addr [4];
    logic [15:0]       ev_data [4];
    logic [2:0]        ev_cnt;

    logic              fail_found;
    logic [2:0]        fail_idx;
    logic [1:0]        fail_kind;
    logic              fail_code;
    logic [AW-1:0]     slot;
    logic [2:0]        pop_cnt;

    assign in_run      = (state_q == ST_RUN);
    // Registered count only: a pop this cycle does not open a slot for this
    // cycle's push.
    assign exp_ready_w = in_run && (count_q < CW'(DEPTH));
    assign push        = bus.exp_valid && exp_ready_w;
    assign bus.exp_ready = exp_ready_w;

    // ---- Stage: build ordered event list for this cycle ----
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ev_kind[i] = K_REG;
            ev_addr[i] = '0;
            ev_data[i] = '0;
        end
        ev_cnt = '0;
        if (bus.RegWrite) begin
            ev_kind[ev_cnt[1:0]] = K_REG;
            ev_addr[ev_cnt[1:0]] = {13'd0, bus.WriteRegister};
            ev_data[ev_cnt[1:0]] = bus.WriteData;
            ev_cnt = ev_cnt + 3'd1;
        end
        if (bus.MemRead) begin
            ev_kind[ev_cnt[1:0]] = K_LOAD;
            ev_addr[ev_cnt[1:0]] = bus.MemAddress;
            ev_data[ev_cnt[1:0]] = bus.MemDataOut;
            ev_cnt = ev_cnt + 3'd1;
        end
        if (bus.MemWrite) begin
            ev_kind[ev_cnt[1:0]] = K_STORE;
            ev_addr[ev_cnt[1:0]] = bus.MemAddress;
            ev_data[ev_cnt[1:0]] = bus.MemDataIn;
            ev_cnt = ev_cnt + 3'd1;
        end
        if (bus.Halt) begin
            ev_kind[ev_cnt[1:0]] = K_HALT;
            ev_addr[ev_cnt[1:0]] = '0;
            ev_data[ev_cnt[1:0]] = '0;
            ev_cnt = ev_cnt + 3'd1;
        end
    end

    // ---- Stage: compare events against FIFO, lowest failing index wins ----
    always_comb begin
        fail_found = 1'b0;
        fail_idx   = '0;
        fail_kind  = '0;
        fail_code  = 1'b0;
        slot       = '0;
        for (int i = 0; i < 4; i++) begin
            if (!fail_found && (3'(i) < ev_cnt)) begin
                slot = rd_ptr_q + AW'(i);
                if (CW'(i) >= count_q) begin
                    // Entry missing: this cycle's push is not yet visible.
                    fail_found = 1'b1;
                    fail_idx   = 3'(i);
                    fail_kind  = ev_kind[i];
                    fail_code  = 1'b1;
                end else if (!rec_match(ev_kind[i], ev_addr[i], ev_data[i],
                                        kind_mem_q[slot], addr_mem_q[slot],
                                        data_mem_q[slot])) begin
                    fail_found = 1'b1;
                    fail_idx   = 3'(i);
                    fail_kind  = ev_kind[i];
                    fail_code  = 1'b0;
                end
            end
        end
    end

    // ---- Stage: next-state and output computation ----
    always_comb begin
        state_d      = state_q;
        mismatch_d   = mismatch_q;
        done_d       = done_q;
        err_kind_d   = err_kind_q;
        err_code_d   = err_code_q;
        rec_index_d  = rec_index_q;
        inst_count_d = inst_count_q;
        pop_cnt      = '0;

        if (in_run) begin
            if (bus.Halt || bus.RegWrite || bus.MemWrite) begin
                inst_count_d = inst_count_q + CNT_W'(1);
            end
            if (fail_found) begin
                state_d     = ST_FAIL;
                mismatch_d  = 1'b1;
                err_kind_d  = fail_kind;
                err_code_d  = fail_code;
                rec_index_d = rec_index_q + CNT_W'(fail_idx);
            end else begin
                pop_cnt     = ev_cnt;
                rec_index_d = rec_index_q + CNT_W'(ev_cnt);
                if (bus.Halt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
        count_d  = count_q + CW'(push) - CW'(pop_cnt);
    end

    // ---- Stage: control / output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            mismatch_q   <= 1'b0;
            done_q       <= 1'b0;
            err_kind_q   <= '0;
            err_code_q   <= 1'b0;
            rec_index_q  <= '0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            mismatch_q   <= mismatch_d;
            done_q       <= done_d;
            err_kind_q   <= err_kind_d;
            err_code_q   <= err_code_d;
            rec_index_q  <= rec_index_d;
            inst_count_q <= inst_count_d;
        end
    end

    // ---- Stage: FIFO storage write ----
    always_ff @(posedge clk) begin
        if (push) begin
            kind_mem_q[wr_ptr_q] <= bus.exp_kind;
            addr_mem_q[wr_ptr_q] <= bus.exp_addr;
            data_mem_q[wr_ptr_q] <= bus.exp_data;
        end
    end

    assign mismatch   = mismatch_q;
    assign done       = done_q;
    assign err_kind   = err_kind_q;
    assign err_code   = err_code_q;
    assign rec_index  = rec_index_q;
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_checker
//   Directed bench for commit_trace_checker. A reference model of the FIFO
//   and status flags predicts the registered outputs for every driven cycle;
//   predictions are queued and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_commit_trace_checker;
    localparam int DEPTH = 8;
    localparam int CNT_W = 32;

    localparam logic [1:0] K_REG   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_HALT  = 2'd3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    commit_trace_if bus();

    logic             mismatch;
    logic             done;
    logic [1:0]       err_kind;
    logic             err_code;
    logic [CNT_W-1:0] rec_index;
    logic [CNT_W-1:0] inst_count;

    commit_trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mismatch   (mismatch),
        .done       (done),
        .err_kind   (err_kind),
        .err_code   (err_code),
        .rec_index  (rec_index),
        .inst_count (inst_count)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    typedef struct packed {
        logic        rw;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        mr;
        logic        mw;
        logic [15:0] maddr;
        logic [15:0] mdin;
        logic [15:0] mdout;
        logic        halt;
    } obs_t;

    typedef struct packed {
        logic        mismatch;
        logic        done;
        logic [1:0]  err_kind;
        logic        err_code;
        logic [31:0] rec_index;
        logic [31:0] inst_count;
        logic        ready;
    } exp_t;

    // Reference model state (0 = RUN, 1 = FAIL, 2 = DONE)
    rec_t        m_fifo[$];
    exp_t        sb[$];
    int          m_state;
    logic        m_mis;
    logic        m_done;
    logic [1:0]  m_ek;
    logic        m_ec;
    logic [31:0] m_rec;
    logic [31:0] m_inst;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic rec_t mk_rec(input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        rec_t r;
        r.kind = k; r.addr = a; r.data = d;
        return r;
    endfunction

    function automatic obs_t o_none();
        obs_t o;
        o = '0;
        return o;
    endfunction

    function automatic obs_t o_reg(input logic [2:0] r, input logic [15:0] d);
        obs_t o;
        o = '0; o.rw = 1'b1; o.wreg = r; o.wdata = d;
        return o;
    endfunction

    function automatic obs_t o_ld(input logic [15:0] a, input logic [15:0] d);
        obs_t o;
        o = '0; o.mr = 1'b1; o.maddr = a; o.mdout = d;
        return o;
    endfunction

    function automatic obs_t o_st(input logic [15:0] a, input logic [15:0] d);
        obs_t o;
        o = '0; o.mw = 1'b1; o.maddr = a; o.mdin = d;
        return o;
    endfunction

    function automatic obs_t o_halt();
        obs_t o;
        o = '0; o.halt = 1'b1;
        return o;
    endfunction

    // Event that exactly satisfies the given record.
    function automatic obs_t o_for(input rec_t r);
        case (r.kind)
            K_REG:   return o_reg(r.addr[2:0], r.data);
            K_LOAD:  return o_ld(r.addr, r.data);
            K_STORE: return o_st(r.addr, r.data);
            default: return o_halt();
        endcase
    endfunction

    function automatic bit m_match(input rec_t r, input logic [1:0] k,
                                   input logic [15:0] a, input logic [15:0] d);
        if (r.kind != k) return 1'b0;
        if (k == K_HALT) return 1'b1;
        if (k == K_REG)  return (r.addr[2:0] == a[2:0]) && (r.data == d);
        return (r.addr == a) && (r.data == d);
    endfunction

    function automatic bit m_ready();
        return (m_state == 0) && (m_fifo.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_state = 0; m_mis = 1'b0; m_done = 1'b0;
        m_ek = '0; m_ec = 1'b0; m_rec = '0; m_inst = '0;
    endtask

    task automatic drive(input bit pv, input rec_t pr, input obs_t o);
        bus.exp_valid     = pv;
        bus.exp_kind      = pr.kind;
        bus.exp_addr      = pr.addr;
        bus.exp_data      = pr.data;
        bus.RegWrite      = o.rw;
        bus.WriteRegister = o.wreg;
        bus.WriteData     = o.wdata;
        bus.MemRead       = o.mr;
        bus.MemWrite      = o.mw;
        bus.MemAddress    = o.maddr;
        bus.MemDataIn     = o.mdin;
        bus.MemDataOut    = o.mdout;
        bus.Halt          = o.halt;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".mismatch"},   64'(mismatch),      64'(e.mismatch));
        chk({tag, ".done"},       64'(done),          64'(e.done));
        chk({tag, ".err_kind"},   64'(err_kind),      64'(e.err_kind));
        chk({tag, ".err_code"},   64'(err_code),      64'(e.err_code));
        chk({tag, ".rec_index"},  64'(rec_index),     64'(e.rec_index));
        chk({tag, ".inst_count"}, 64'(inst_count),    64'(e.inst_count));
        chk({tag, ".exp_ready"},  64'(bus.exp_ready), 64'(e.ready));
    endtask

    // One clock cycle: drive, predict, enqueue prediction, clock, compare.
    task automatic step(input string tag, input bit pv, input rec_t pr, input obs_t o);
        logic [1:0]  ek [4];
        logic [15:0] ea [4];
        logic [15:0] ed [4];
        int          k;
        bit          push;
        bit          bad;
        int          bi;
        logic [1:0]  bk;
        logic        bc;
        exp_t        e;

        drive(pv, pr, o);
        #1;
        chk({tag, ".ready_pre"}, 64'(bus.exp_ready), 64'(m_ready()));
        push = pv && m_ready();
        k = 0; bad = 1'b0; bi = 0; bk = '0; bc = 1'b0;
        if (m_state == 0) begin
            if (o.rw)   begin ek[k] = K_REG;   ea[k] = {13'd0, o.wreg}; ed[k] = o.wdata; k++; end
            if (o.mr)   begin ek[k] = K_LOAD;  ea[k] = o.maddr;         ed[k] = o.mdout; k++; end
            if (o.mw)   begin ek[k] = K_STORE; ea[k] = o.maddr;         ed[k] = o.mdin;  k++; end
            if (o.halt) begin ek[k] = K_HALT;  ea[k] = '0;              ed[k] = '0;      k++; end
            for (int i = 0; i < k; i++) begin
                if (!bad) begin
                    if (i >= m_fifo.size()) begin
                        bad = 1'b1; bi = i; bk = ek[i]; bc = 1'b1;
                    end else if (!m_match(m_fifo[i], ek[i], ea[i], ed[i])) begin
                        bad = 1'b1; bi = i; bk = ek[i]; bc = 1'b0;
                    end
                end
            end
            if (o.rw || o.mw || o.halt) m_inst = m_inst + 1;
            if (bad) begin
                m_state = 1; m_mis = 1'b1; m_ek = bk; m_ec = bc;
                m_rec = m_rec + 32'(bi);
            end else begin
                for (int i = 0; i < k; i++) void'(m_fifo.pop_front());
                m_rec = m_rec + 32'(k);
                if (o.halt) begin m_state = 2; m_done = 1'b1; end
            end
        end
        if (push) m_fifo.push_back(pr);
        e.mismatch = m_mis; e.done = m_done; e.err_kind = m_ek; e.err_code = m_ec;
        e.rec_index = m_rec; e.inst_count = m_inst; e.ready = m_ready();
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        exp_t e;
        drive(1'b0, '0, o_none());
        rst = 1'b1;
        #2;
        model_reset();
        e = '0; e.ready = 1'b1;
        check_outputs({tag, ".rst"}, e);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        rec_t r0;
        rec_t nr;

        r0  = '0;
        rst = 1'b1;
        drive(1'b0, r0, o_none());
        model_reset();
        do_reset("t1");

        // Single REG record then matching write
        step("t1.push", 1'b1, mk_rec(K_REG, 16'h0003, 16'h1234), o_none());
        step("t1.reg",  1'b0, r0, o_reg(3'd3, 16'h1234));

        // Two events in one cycle consume two entries
        step("t2.push0", 1'b1, mk_rec(K_REG,  16'h0001, 16'h00AA), o_none());
        step("t2.push1", 1'b1, mk_rec(K_LOAD, 16'h0040, 16'h00AA), o_none());
        o = o_reg(3'd1, 16'h00AA); o.mr = 1'b1; o.maddr = 16'h0040; o.mdout = 16'h00AA;
        step("t2.both",  1'b0, r0, o);

        // Store data mismatch, then everything frozen
        do_reset("t3");
        step("t3.push",   1'b1, mk_rec(K_STORE, 16'h0010, 16'hBEEF), o_none());
        step("t3.bad",    1'b0, r0, o_st(16'h0010, 16'hBEEE));
        step("t3.frozen", 1'b1, mk_rec(K_REG, 16'h0001, 16'h0002), o_reg(3'd1, 16'h0002));

        // Underflow: push in the same cycle is not visible
        do_reset("t4");
        step("t4.uflow",  1'b1, mk_rec(K_REG, 16'h0005, 16'h0007), o_reg(3'd5, 16'h0007));
        step("t4.frozen", 1'b0, r0, o_halt());

        // Second event of a cycle fails its data compare
        do_reset("t7");
        step("t7.push0", 1'b1, mk_rec(K_REG,  16'h0002, 16'h0005), o_none());
        step("t7.push1", 1'b1, mk_rec(K_LOAD, 16'h0020, 16'h0007), o_none());
        o = o_reg(3'd2, 16'h0005); o.mr = 1'b1; o.maddr = 16'h0020; o.mdout = 16'h0008;
        step("t7.bad",   1'b0, r0, o);

        // Second event of a cycle has no entry
        do_reset("t8");
        step("t8.push", 1'b1, mk_rec(K_REG, 16'h0004, 16'h0044), o_none());
        o = o_reg(3'd4, 16'h0044); o.mw = 1'b1; o.maddr = 16'h0100; o.mdin = 16'h0001;
        step("t8.uflow", 1'b0, r0, o);

        // Fill to DEPTH, refuse extra push, free a slot, then wrap
        do_reset("t5");
        for (int i = 0; i < DEPTH + 1; i++) begin
            nr = mk_rec(K_REG, 16'hFFF8 | 16'(i), 16'(i * 16'h0111));
            step("t5.fill", 1'b1, nr, o_none());
        end
        step("t5.pop_full", 1'b1, mk_rec(K_REG, 16'h0000, 16'h0999), o_for(m_fifo[0]));
        for (int i = 0; i < 24; i++) begin
            nr = mk_rec(2'(i % 3), 16'($urandom), 16'($urandom));
            step("t5.wrap", 1'b1, nr, o_for(m_fifo[0]));
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_fifo.size() > 0) step("t5.drain", 1'b0, r0, o_for(m_fifo[0]));
        end

        // Clean HALT together with the last register write
        do_reset("t6");
        step("t6.push0", 1'b1, mk_rec(K_REG,  16'h0002, 16'h0005), o_none());
        step("t6.push1", 1'b1, mk_rec(K_HALT, 16'h0000, 16'h0000), o_none());
        o = o_reg(3'd2, 16'h0005); o.halt = 1'b1;
        step("t6.halt",   1'b0, r0, o);
        step("t6.frozen", 1'b1, mk_rec(K_REG, 16'h0001, 16'h0001), o_reg(3'd1, 16'h0001));

        // Reset asserted while in FAIL
        do_reset("t9");
        step("t9.uflow", 1'b0, r0, o_reg(3'd0, 16'h0000));
        do_reset("t9.midfail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
